// File: rtl/axis_iir_cascade.sv
// axis_iir_cascade: AXI-Stream cascade of first-order IIR sections with a global advance enable.
// Define AXIS_IIR_CASCADE_CLAMP_EN to clamp the final value to [out_min, out_max] instead of wrapping.
module axis_iir_cascade #(
  parameter int DATA_WIDTH = 16,
  parameter int COEF_WIDTH = 16,
  parameter int FRAC_BITS  = 14,
  parameter int STAGES     = 3,
  parameter int GUARD      = 8
) (
  input  logic                                           aclk,
  input  logic                                           areset,
  input  logic                                           clear,
  input  logic [STAGES*2*COEF_WIDTH+2*DATA_WIDTH-1:0]    cfg_data,
  input  logic [DATA_WIDTH-1:0]                          s_axis_tdata,
  input  logic                                           s_axis_tvalid,
  output logic                                           s_axis_tready,
  output logic [DATA_WIDTH-1:0]                          m_axis_tdata,
  output logic                                           m_axis_tvalid,
  input  logic                                           m_axis_tready
);
  localparam int IW = DATA_WIDTH + GUARD;
  localparam int AW = COEF_WIDTH + IW + 1;
  localparam int CB = STAGES * 2 * COEF_WIDTH;
  logic signed [IW-1:0] y_q [STAGES];
  logic signed [IW-1:0] y_d [STAGES];
  logic signed [IW-1:0] st_q [STAGES];
  logic signed [IW-1:0] st_d [STAGES];
  logic [STAGES-1:0] v_q, v_d;
  logic [DATA_WIDTH-1:0] m_data_q, m_data_d, red;
  logic m_valid_q, m_valid_d, rdy_q, ce;
  logic signed [IW-1:0] fin;

  // rdy_q holds tready low until the first edge after reset release
  assign ce            = (~m_valid_q | m_axis_tready) & ~clear & rdy_q;
  assign s_axis_tready = ce;
  assign m_axis_tdata  = m_data_q;
  assign m_axis_tvalid = m_valid_q;
  assign fin           = y_q[STAGES-1];

`ifdef AXIS_IIR_CASCADE_CLAMP_EN
  logic signed [IW-1:0] lo, hi, cl;
  logic unused_w;
  assign lo       = {{GUARD{cfg_data[CB+DATA_WIDTH-1]}}, cfg_data[CB +: DATA_WIDTH]};
  assign hi       = {{GUARD{cfg_data[CB+2*DATA_WIDTH-1]}}, cfg_data[CB+DATA_WIDTH +: DATA_WIDTH]};
  assign cl       = (fin < lo) ? lo : (fin > hi) ? hi : fin;
  assign red      = cl[DATA_WIDTH-1:0];
  assign unused_w = ^cl[IW-1:DATA_WIDTH];
`else
  logic unused_w;
  assign red      = fin[DATA_WIDTH-1:0];
  assign unused_w = ^{cfg_data[CB +: 2*DATA_WIDTH], fin[IW-1:DATA_WIDTH]};
`endif

  always_comb begin
    logic signed [IW-1:0] xin [STAGES];
    logic [STAGES-1:0] vin;
    logic signed [COEF_WIDTH-1:0] b, a;
    logic signed [AW-1:0] acc, sh;
    logic signed [IW-1:0] y;
    xin[0] = {{GUARD{s_axis_tdata[DATA_WIDTH-1]}}, s_axis_tdata};
    vin[0] = s_axis_tvalid;
    for (int k = 1; k < STAGES; k++) begin
      xin[k] = y_q[k-1];
      vin[k] = v_q[k-1];
    end
    y_d = y_q;
    st_d = st_q;
    v_d = v_q;
    b = '0;
    a = '0;
    acc = '0;
    sh = '0;
    y = '0;
    for (int k = 0; k < STAGES; k++) begin
      b   = $signed(cfg_data[2*k*COEF_WIDTH +: COEF_WIDTH]);
      a   = $signed(cfg_data[(2*k+1)*COEF_WIDTH +: COEF_WIDTH]);
      acc = AW'(b) * AW'(xin[k]) + AW'(a) * AW'(st_q[k]);
      sh  = acc >>> FRAC_BITS;
      y   = (&sh[AW-1:IW-1] | ~|sh[AW-1:IW-1]) ? sh[IW-1:0] : {sh[AW-1], {(IW-1){~sh[AW-1]}}};
      if (ce) begin
        y_d[k] = y;
        v_d[k] = vin[k];
        if (vin[k]) st_d[k] = y;
      end
      if (clear) begin
        v_d[k]  = 1'b0;
        st_d[k] = '0;
      end
    end
    m_data_d  = ce ? red : m_data_q;
    m_valid_d = clear ? 1'b0 : ce ? v_q[STAGES-1] : m_valid_q;
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      for (int k = 0; k < STAGES; k++) begin
        y_q[k]  <= '0;
        st_q[k] <= '0;
      end
      v_q       <= '0;
      m_data_q  <= '0;
      m_valid_q <= 1'b0;
      rdy_q     <= 1'b0;
    end else begin
      y_q       <= y_d;
      st_q      <= st_d;
      v_q       <= v_d;
      m_data_q  <= m_data_d;
      m_valid_q <= m_valid_d;
      rdy_q     <= 1'b1;
    end
  end
endmodule

// File: tb/tb_axis_iir_cascade.sv
// tb_axis_iir_cascade: directed tests of the two-section IIR cascade with hand-computed outputs.
module tb_axis_iir_cascade;
  localparam int DW = 16, CW = 16, ST = 2;
  logic clk = 1'b0, rst = 1'b1, clr = 1'b0, in_v = 1'b0, out_r = 1'b1;
  logic [ST*2*CW+2*DW-1:0] cfg = '0;
  logic signed [DW-1:0] in_d = '0;
  logic signed [DW-1:0] out_d;
  logic in_r, out_v;
  int checks = 0, errors = 0;
  logic signed [DW-1:0] stim [16];
  logic signed [DW-1:0] got [16];
  int got_n, lat, stall_bad, stall_seen;

  always #5 clk = ~clk;

  axis_iir_cascade #(.DATA_WIDTH(DW), .COEF_WIDTH(CW), .FRAC_BITS(14), .STAGES(ST), .GUARD(8)) dut (
    .aclk(clk), .areset(rst), .clear(clr), .cfg_data(cfg),
    .s_axis_tdata(in_d), .s_axis_tvalid(in_v), .s_axis_tready(in_r),
    .m_axis_tdata(out_d), .m_axis_tvalid(out_v), .m_axis_tready(out_r)
  );

  task automatic set_cfg(input int b0, input int a0, input int b1, input int a1, input int omin, input int omax);
    cfg = {omax[15:0], omin[15:0], a1[15:0], b1[15:0], a0[15:0], b0[15:0]};
  endtask

  task automatic flush();
    @(negedge clk);
    in_v = 1'b0;
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
  endtask

  task automatic run(input int n, input int s0, input int sl);
    int i = 0, first = 0;
    logic prev_hold = 1'b0;
    logic signed [DW-1:0] prev_d = '0;
    got_n = 0; lat = -1; stall_bad = 0; stall_seen = 0;
    for (int c = 0; c < 100 && got_n < n; c++) begin
      @(negedge clk);
      out_r = !(c >= s0 && c < s0 + sl);
      in_v = i < n;
      in_d = (i < n) ? stim[i] : '0;
      #1;
      if (!out_r && out_v) begin
        stall_seen++;
        if (in_r || (prev_hold && out_d !== prev_d)) stall_bad++;
      end
      prev_hold = !out_r && out_v;
      prev_d = out_d;
      if (in_v && in_r && i == 0) first = c;
      if (out_v && out_r && got_n == 0) lat = c - first;
      if (in_v && in_r) i++;
      if (out_v && out_r) begin
        got[got_n] = out_d;
        got_n++;
      end
    end
    @(negedge clk);
    in_v = 1'b0;
    out_r = 1'b1;
  endtask

  task automatic test_reset();
    #1;
    checks++;
    if (out_v !== 1'b0 || out_d !== '0 || in_r !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: got tvalid=%b tdata=%0d tready=%b, expected 0 0 0", out_v, out_d, in_r);
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++;
    if (in_r !== 1'b0) begin errors++; $display("FAIL ready_before_edge: got %b expected 0", in_r); end
    @(posedge clk);
    #1;
    checks++;
    if (in_r !== 1'b1) begin errors++; $display("FAIL ready_after_edge: got %b expected 1", in_r); end
  endtask

  task automatic test_passthrough();
    flush();
    set_cfg(16384, 0, 16384, 0, -32768, 32767);
    stim[0] = 16'sd1000;
    run(1, 0, 0);
    checks++;
    if (got_n !== 1 || got[0] !== 16'sd1000) begin errors++; $display("FAIL pass_1000: got %0d (n=%0d) expected 1000", got[0], got_n); end
    checks++;
    if (lat !== 3) begin errors++; $display("FAIL pass_latency: got %0d expected 3", lat); end
    stim[0] = -16'sd32768;
    run(1, 0, 0);
    checks++;
    if (got_n !== 1 || got[0] !== -16'sd32768) begin errors++; $display("FAIL pass_min: got %0d expected -32768", got[0]); end
  endtask

  task automatic test_step();
    logic signed [DW-1:0] e [4] = '{16'sd500, 16'sd750, 16'sd875, 16'sd937};
    flush();
    set_cfg(16384, 0, 8192, 8192, -32768, 32767);
    for (int i = 0; i < 4; i++) stim[i] = 16'sd1000;
    run(4, 0, 0);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (i >= got_n || got[i] !== e[i]) begin errors++; $display("FAIL step_%0d: got %0d expected %0d", i, got[i], e[i]); end
    end
  endtask

  task automatic test_saturation();
`ifdef AXIS_IIR_CASCADE_CLAMP_EN
    logic signed [DW-1:0] e [2] = '{16'sd1000, -16'sd1000};
`else
    logic signed [DW-1:0] e [2] = '{-16'sd25538, 16'sd25537};
`endif
    flush();
    set_cfg(16384, 0, 32767, 0, -1000, 1000);
    stim[0] = 16'sd20000;
    stim[1] = -16'sd20000;
    run(2, 0, 0);
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (i >= got_n || got[i] !== e[i]) begin errors++; $display("FAIL sat_%0d: got %0d expected %0d", i, got[i], e[i]); end
    end
  endtask

  task automatic test_backpressure();
    logic signed [DW-1:0] e [3] = '{16'sd11, -16'sd22, 16'sd33};
    flush();
    set_cfg(16384, 0, 16384, 0, -32768, 32767);
    for (int i = 0; i < 3; i++) stim[i] = e[i];
    run(3, 2, 5);
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (i >= got_n || got[i] !== e[i]) begin errors++; $display("FAIL bp_%0d: got %0d expected %0d", i, got[i], e[i]); end
    end
    checks++;
    if (stall_seen < 3 || stall_bad !== 0) begin
      errors++;
      $display("FAIL bp_stall: got %0d stalled cycles with %0d violations, expected >=3 with 0", stall_seen, stall_bad);
    end
  endtask

  task automatic test_clear();
    int n_out = 0, post = 0, at = -1;
    logic signed [DW-1:0] after [2] = '{16'sd0, 16'sd0};
    flush();
    set_cfg(16384, 0, 8192, 8192, -32768, 32767);
    for (int c = 0; c < 40 && post < 2; c++) begin
      @(negedge clk);
      in_v = 1'b1;
      in_d = 16'sd1000;
      clr = (n_out == 2 && at < 0);
      #1;
      if (clr) at = c;
      if (at >= 0 && c == at + 1) begin
        checks++;
        if (out_v !== 1'b0) begin errors++; $display("FAIL clear_valid: got %b expected 0", out_v); end
      end
      if (out_v && out_r && !clr) begin
        if (at < 0) n_out++;
        else begin after[post] = out_d; post++; end
      end
    end
    @(negedge clk);
    in_v = 1'b0;
    clr = 1'b0;
    checks++;
    if (post !== 2 || after[0] !== 16'sd500 || after[1] !== 16'sd750) begin
      errors++;
      $display("FAIL clear_restart: got %0d,%0d (n=%0d) expected 500,750", after[0], after[1], post);
    end
  endtask

  task automatic test_async_reset();
    logic signed [DW-1:0] e [4] = '{16'sd500, 16'sd750, 16'sd875, 16'sd937};
    flush();
    set_cfg(16384, 0, 8192, 8192, -32768, 32767);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      in_v = 1'b1;
      in_d = 16'sd1000;
    end
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (out_v !== 1'b0 || in_r !== 1'b0) begin
      errors++;
      $display("FAIL areset_immediate: got tvalid=%b tready=%b expected 0 0", out_v, in_r);
    end
    in_v = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    for (int i = 0; i < 4; i++) stim[i] = 16'sd1000;
    run(4, 0, 0);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (i >= got_n || got[i] !== e[i]) begin errors++; $display("FAIL areset_fresh_%0d: got %0d expected %0d", i, got[i], e[i]); end
    end
  endtask

  initial begin
    test_reset();
    test_passthrough();
    test_step();
    test_saturation();
    test_backpressure();
    test_clear();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/axis_iir_cascade.md
AXIS_IIR_CASCADE -- requirements
Module: axis_iir_cascade

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 16, meaning signed sample width in and out.
REQ-002 SHALL have parameter COEF_WIDTH, default 16, meaning signed coefficient width.
REQ-003 SHALL have parameter FRAC_BITS, default 14, meaning coefficient fractional bits.
REQ-004 SHALL have parameter STAGES, default 3, range 1..8, meaning the number of cascaded first-order sections.
REQ-005 SHALL have parameter GUARD, default 8, meaning the extra internal bits; internal width IW = DATA_WIDTH+GUARD.
REQ-006 SHALL have port aclk, input, width 1, the only clock.
REQ-007 SHALL have port areset, input, width 1, reset: asynchronous, active-high.
REQ-008 SHALL have port clear, input, width 1, synchronous flush of filter state.
REQ-009 SHALL have port cfg_data, input, width STAGES*2*COEF_WIDTH+2*DATA_WIDTH: section k b_k at [2k*CW +: CW], a_k at [(2k+1)*CW +: CW], out_min then out_max above the coefficients.
REQ-010 SHALL have port s_axis_tdata, input, width DATA_WIDTH, signed sample.
REQ-011 SHALL have ports s_axis_tvalid (input, 1) and s_axis_tready (output, 1), the slave handshake.
REQ-012 SHALL have port m_axis_tdata, output, width DATA_WIDTH, filtered sample.
REQ-013 SHALL have ports m_axis_tvalid (output, 1) and m_axis_tready (input, 1), the master handshake.

Function
REQ-014 SHALL compute per section k: acc = b_k*x_k + a_k*y_k[n-1], full precision; y_k = acc >>> FRAC_BITS (arithmetic, floor), saturated to IW bits; x_0 = sign-extended input, x_{k+1} = y_k.
REQ-015 SHALL register each section output once: pipeline of STAGES section registers plus one output register.
REQ-016 SHALL use a global advance enable ce = (~m_axis_tvalid | m_axis_tready) & ~clear; s_axis_tready = ce.
REQ-017 SHALL, when ce=1, shift every stage's data and valid bit one place; when ce=0, freeze the pipeline.
REQ-018 SHALL update y_k[n-1] only when stage k captures a valid sample under ce; bubbles SHALL NOT alter state.
REQ-019 SHALL have latency STAGES+1 cycles from input handshake to m_axis_tvalid with no backpressure; throughput one sample/cycle.
REQ-020 SHALL keep m_axis_tdata stable while m_axis_tvalid=1 and m_axis_tready=0.
REQ-021 SHALL lose, duplicate or reorder no sample under any tready pattern.
REQ-022 SHALL reduce the output from IW to DATA_WIDTH per REQ-029/REQ-030.
REQ-023 SHALL, with clear=1 at an edge, zero all y_k[n-1], all valid bits and m_axis_tvalid, accepting no input that cycle; clear wins over simultaneous handshakes.
REQ-024 SHALL sample cfg_data every cycle; coefficient changes SHALL apply to the next computation without flushing.

Reset
REQ-025 SHALL, on areset high, asynchronously clear m_axis_tvalid=0, m_axis_tdata=0, all valid bits and states=0.
REQ-026 SHALL drive s_axis_tready=0 while areset is high; 1 on the first edge after release.
REQ-027 SHALL discard samples in flight when reset is asserted mid-stream; the first post-reset output SHALL derive only from post-reset inputs.

Configuration
REQ-028 SHALL honour macro AXIS_IIR_CASCADE_CLAMP_EN.
REQ-029 SHALL, when AXIS_IIR_CASCADE_CLAMP_EN is defined, clamp the final IW value to [out_min, out_max] (signed) before the output register.
REQ-030 SHALL, when AXIS_IIR_CASCADE_CLAMP_EN is undefined, output the low DATA_WIDTH bits (two's-complement wrap) and ignore the out_min/out_max fields.

Verification (DATA_WIDTH=16, COEF_WIDTH=16, FRAC_BITS=14, STAGES=2, GUARD=8, m_axis_tready=1 unless stated)
REQ-031 SHALL cover passthrough: b=16384, a=0 both sections; input 1000 -> output 1000 exactly 3 cycles after the handshake; input -32768 -> -32768.
REQ-032 SHALL cover step response: section0 b=16384 a=0, section1 b=8192 a=8192; constant 1000 -> outputs 500, 750, 875, 937.
REQ-033 SHALL cover saturation: section1 b=32767; input 20000 -> stage value 39998; with the macro and out_max=1000 -> 1000; without it -> -25538.
REQ-034 SHALL cover backpressure: 3 samples with m_axis_tready low for 5 cycles -> s_axis_tready low during the stall, tdata held, all 3 outputs in order and correct.
REQ-035 SHALL cover clear mid-step (REQ-032 setup): pulse clear after the 2nd output -> no valid output that cycle, then the sequence restarts at 500.
REQ-036 SHALL cover async reset mid-stream: assert areset between edges -> m_axis_tvalid=0 immediately; post-release outputs match a fresh run.
